// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Fetch/decode/execute control for the small micro processor. Owns the
//   program counter, fetches 11-bit instructions over a req/ack handshake,
//   latches them into the instruction register and hands the fields to the
//   decoder with a valid strobe. ALU ops, memory ops (with a completion
//   timeout), jumps and halt are sequenced here.
//
// Ports
//   clk, rstn          clock (rising edge), async active-low reset
//   start              begin execution at pc=0 (only honoured in IDLE/HALT)
//   imem_req/addr      fetch request and address (address = pc)
//   imem_ack/data      fetch data valid and instruction word
//   opcode/mem_addr/imm_val, dec_en   decoder fields from IR and their strobe
//   zero_flag          ALU zero result, used by JZ
//   mem_done           data memory access complete
//   pc                 current program counter
//   busy, halted       run-state indicators
//   error              sticky memory-timeout flag (cleared by reset or start)
//   retired            completed-instruction count, wraps
//
// State table
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   FETCH   | imem_req high, waiting for imem_ack
//   DECODE  | one cycle, IR fields presented, branch/halt resolved here
//   EXEC    | one cycle, ALU/NOP instruction completes
//   MEMWAIT | waiting for mem_done, bounded by MEM_TIMEOUT cycles
//   HALT    | stopped by HALT opcode or memory timeout, waiting for start

module instr_sequencer #(
   parameter int PC_WIDTH    = 4,
   parameter int MEM_TIMEOUT = 8,
   parameter int RET_WIDTH   = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [10:0]          imem_data,
   output logic [2:0]           opcode,
   output logic [3:0]           mem_addr,
   output logic [3:0]           imm_val,
   output logic                 dec_en,
   input  logic                 zero_flag,
   input  logic                 mem_done,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 busy,
   output logic                 halted,
   output logic                 error,
   output logic [RET_WIDTH-1:0] retired
);

   // Counter only has to reach MEM_TIMEOUT-1.
   localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_DECODE  = 3'd2,
      S_EXEC    = 3'd3,
      S_MEMWAIT = 3'd4,
      S_HALT    = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_LOAD  = 3'd1,
      OP_STORE = 3'd2,
      OP_ADDI  = 3'd3,
      OP_SUBI  = 3'd4,
      OP_JMP   = 3'd5,
      OP_JZ    = 3'd6,
      OP_HALT  = 3'd7
   } op_e;

   state_e               state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [10:0]          ir_q, ir_d;
   logic                 err_q, err_d;
   logic [RET_WIDTH-1:0] ret_q, ret_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PC_WIDTH-1:0]  imm_ext;
   op_e                  ir_op;

   assign ir_op = op_e'(ir_q[10:8]);

   // Zero-extend (or truncate, for very narrow PCs) the 4-bit immediate.
   always_comb begin
      imm_ext = '0;
      for (int i = 0; i < 4 && i < PC_WIDTH; i++) begin
         imm_ext[i] = ir_q[i];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         ir_q    <= '0;
         err_q   <= 1'b0;
         ret_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         err_q   <= err_d;
         ret_q   <= ret_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      err_d   = err_q;
      ret_d   = ret_q;
      cnt_d   = cnt_q;

      case (state_q)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_d    = '0;
               err_d   = 1'b0;
               ret_d   = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_data;
               pc_d    = pc_q + PC_WIDTH'(1);
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            case (ir_op)
               OP_NOP, OP_ADDI, OP_SUBI: state_d = S_EXEC;
               OP_LOAD, OP_STORE: begin
                  cnt_d   = '0;
                  state_d = S_MEMWAIT;
               end
               OP_JMP: begin
                  pc_d    = imm_ext;
                  ret_d   = ret_q + RET_WIDTH'(1);
                  state_d = S_FETCH;
               end
               OP_JZ: begin
                  if (zero_flag) begin
                     pc_d = imm_ext;
                  end
                  ret_d   = ret_q + RET_WIDTH'(1);
                  state_d = S_FETCH;
               end
               OP_HALT: state_d = S_HALT;
               default: state_d = S_HALT;
            endcase
         end

         S_EXEC: begin
            ret_d   = ret_q + RET_WIDTH'(1);
            state_d = S_FETCH;
         end

         S_MEMWAIT: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Completion takes priority over a timeout in the same cycle.
            if (mem_done) begin
               ret_d   = ret_q + RET_WIDTH'(1);
               state_d = S_FETCH;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = S_HALT;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req = 1'b0;
      dec_en   = 1'b0;
      busy     = 1'b0;
      halted   = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_req = 1'b1;
            busy     = 1'b1;
         end
         S_DECODE, S_EXEC, S_MEMWAIT: begin
            dec_en = 1'b1;
            busy   = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         default: ;
      endcase
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign opcode    = ir_q[10:8];
   assign mem_addr  = ir_q[7:4];
   assign imm_val   = ir_q[3:0];
   assign error     = err_q;
   assign retired   = ret_q;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   localparam int PCW = 4;
   localparam int MTO = 4;
   localparam int RW  = 8;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic           start = 1'b0;
   logic           imem_ack = 1'b0;
   logic [10:0]    imem_data = '0;
   logic           zero_flag = 1'b0;
   logic           mem_done = 1'b0;
   logic           imem_req;
   logic [PCW-1:0] imem_addr;
   logic [2:0]     opcode;
   logic [3:0]     mem_addr;
   logic [3:0]     imm_val;
   logic           dec_en;
   logic [PCW-1:0] pc;
   logic           busy;
   logic           halted;
   logic           error;
   logic [RW-1:0]  retired;

   instr_sequencer #(.PC_WIDTH(PCW), .MEM_TIMEOUT(MTO), .RET_WIDTH(RW)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .start     (start),
      .imem_req  (imem_req),
      .imem_addr (imem_addr),
      .imem_ack  (imem_ack),
      .imem_data (imem_data),
      .opcode    (opcode),
      .mem_addr  (mem_addr),
      .imm_val   (imm_val),
      .dec_en    (dec_en),
      .zero_flag (zero_flag),
      .mem_done  (mem_done),
      .pc        (pc),
      .busy      (busy),
      .halted    (halted),
      .error     (error),
      .retired   (retired)
   );

   always #5 clk = ~clk;

   logic [10:0] imem [16];
   bit          ack_en = 1'b1;
   int          mem_delay = 0;   // MEMWAIT cycle on which mem_done is raised; 0 = never

   int n_chk  = 0;
   int n_pass = 0;

   logic [PCW-1:0]      q_fetch [$];
   logic [10:0]         q_dec   [$];
   int                  q_run   [$];
   logic [PCW+RW+2:0]   q_halt  [$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   task automatic unexpected(input string name, input logic [31:0] got);
      n_chk++;
      $display("FAIL %s: unexpected event, value 0x%0h, nothing expected", name, got);
   endtask

   function automatic logic [10:0] ins(input logic [2:0] op, input logic [3:0] ma, input logic [3:0] im);
      return {op, ma, im};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 16; i++) imem[i] = '0;
   endtask

   task automatic exp_f(input int a);
      q_fetch.push_back(PCW'(a));
   endtask

   task automatic exp_d(input int op, input int ma, input int im);
      q_dec.push_back(ins(3'(op), 4'(ma), 4'(im)));
   endtask

   task automatic exp_h(input int p, input int r, input int e);
      q_halt.push_back({PCW'(p), RW'(r), 1'(e), 2'b00});
   endtask

   // Instruction memory and data memory responder, driven just after the edge.
   initial begin : responder
      int run;
      run = 0;
      forever begin
         @(posedge clk);
         #1;
         run       = dec_en ? run + 1 : 0;
         imem_ack  = ack_en && imem_req;
         imem_data = imem[imem_addr];
         mem_done  = dec_en && (opcode == 3'd1 || opcode == 3'd2) &&
                     (mem_delay > 0) && (run == mem_delay + 1);
      end
   end

   // Monitor: pops expectations whenever the DUT presents an event.
   initial begin : monitor
      logic dec_prev, halt_prev;
      int   run;
      dec_prev  = 1'b0;
      halt_prev = 1'b0;
      run       = 0;
      forever begin
         @(negedge clk);
         if (imem_req && imem_ack) begin
            if (q_fetch.size() == 0) unexpected("fetch_addr", 32'(imem_addr));
            else check("fetch_addr", 32'(imem_addr), 32'(q_fetch.pop_front()));
         end
         if (dec_en && !dec_prev) begin
            if (q_dec.size() == 0) unexpected("decode_fields", 32'({opcode, mem_addr, imm_val}));
            else check("decode_fields", 32'({opcode, mem_addr, imm_val}), 32'(q_dec.pop_front()));
         end
         if (dec_en) begin
            run++;
         end else if (run > 0) begin
            if (q_run.size() == 0) unexpected("dec_en_cycles", 32'(run));
            else check("dec_en_cycles", 32'(run), 32'(q_run.pop_front()));
            run = 0;
         end
         if (halted && !halt_prev) begin
            if (q_halt.size() == 0) unexpected("halt_state", 32'({pc, retired, error, busy, dec_en}));
            else check("halt_state", 32'({pc, retired, error, busy, dec_en}), 32'(q_halt.pop_front()));
         end
         dec_prev  = dec_en;
         halt_prev = halted;
      end
   end

   task automatic check_all_zero(input string name);
      check(name, 32'({imem_req, dec_en, busy, halted, error, pc, imem_addr, retired,
                       opcode, mem_addr, imm_val}), 32'(0));
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_state", 32'({busy, error, pc, retired}), 32'({1'b1, 1'b0, PCW'(0), RW'(0)}));
   endtask

   task automatic wait_halt(input int budget);
      int k;
      k = 0;
      while (!halted && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("halt_reached", 32'(halted), 32'(1));
   endtask

   initial begin : stimulus
      clear_imem();

      // Reset: outputs zero, start ignored while in reset, IDLE held afterwards.
      rstn  = 1'b0;
      start = 1'b1;
      repeat (2) @(negedge clk);
      check_all_zero("reset_values");
      rstn  = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_hold", 32'({busy, halted, imem_req}), 32'(0));

      // Reset asserted mid-FETCH, late ack must be ignored.
      ack_en  = 1'b0;
      imem[0] = ins(3'd3, 4'd0, 4'd2);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("fetch_before_reset", 32'({imem_req, busy}), 32'(2'b11));
      @(posedge clk);
      #3;
      rstn = 1'b0;
      #1;
      check_all_zero("reset_async");
      ack_en = 1'b1;
      @(negedge clk);
      check("late_ack_ignored", 32'({imem_req, dec_en, busy}), 32'(0));
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      check("idle_after_reset", 32'({busy, halted}), 32'(0));

      // Straight line: ADDI then HALT.
      clear_imem();
      imem[0] = ins(3'd3, 4'd0, 4'd2);
      imem[1] = ins(3'd7, 4'd0, 4'd0);
      exp_f(0); exp_f(1);
      exp_d(3, 0, 2); exp_d(7, 0, 0);
      q_run.push_back(2); q_run.push_back(1);
      exp_h(2, 1, 0);
      do_start();
      wait_halt(50);

      // LOAD completing on the third MEMWAIT cycle.
      clear_imem();
      mem_delay = 3;
      imem[0] = ins(3'd1, 4'd3, 4'd0);
      imem[1] = ins(3'd7, 4'd0, 4'd0);
      exp_f(0); exp_f(1);
      exp_d(1, 3, 0); exp_d(7, 0, 0);
      q_run.push_back(4); q_run.push_back(1);
      exp_h(2, 1, 0);
      do_start();
      wait_halt(50);

      // STORE that never completes: timeout after MTO cycles.
      clear_imem();
      mem_delay = 0;
      imem[0] = ins(3'd2, 4'd5, 4'd0);
      imem[1] = ins(3'd7, 4'd0, 4'd0);
      exp_f(0);
      exp_d(2, 5, 0);
      q_run.push_back(1 + MTO);
      exp_h(1, 0, 1);
      do_start();
      wait_halt(50);

      // Same STORE, mem_done on the last allowed cycle: completion wins.
      mem_delay = MTO;
      exp_f(0); exp_f(1);
      exp_d(2, 5, 0); exp_d(7, 0, 0);
      q_run.push_back(1 + MTO); q_run.push_back(1);
      exp_h(2, 1, 0);
      do_start();
      wait_halt(50);
      mem_delay = 0;

      // JZ not taken.
      clear_imem();
      zero_flag = 1'b0;
      imem[0] = ins(3'd6, 4'd0, 4'd9);
      imem[1] = ins(3'd7, 4'd0, 4'd0);
      imem[9] = ins(3'd7, 4'd0, 4'd0);
      exp_f(0); exp_f(1);
      exp_d(6, 0, 9); exp_d(7, 0, 0);
      q_run.push_back(1); q_run.push_back(1);
      exp_h(2, 1, 0);
      do_start();
      wait_halt(50);

      // JZ taken.
      zero_flag = 1'b1;
      exp_f(0); exp_f(9);
      exp_d(6, 0, 9); exp_d(7, 0, 0);
      q_run.push_back(1); q_run.push_back(1);
      exp_h(10, 1, 0);
      do_start();
      wait_halt(50);
      zero_flag = 1'b0;

      // JMP 15, NOP at 15, pc wraps to 0 where HALT is placed once 15 is fetched.
      clear_imem();
      imem[0]  = ins(3'd5, 4'd0, 4'd15);
      imem[15] = ins(3'd0, 4'd0, 4'd0);
      exp_f(0); exp_f(15); exp_f(0);
      exp_d(5, 0, 15); exp_d(0, 0, 0); exp_d(7, 0, 0);
      q_run.push_back(1); q_run.push_back(2); q_run.push_back(1);
      exp_h(1, 2, 0);
      do_start();
      begin
         int k;
         k = 0;
         while (!(imem_req && imem_addr == 4'd15) && k < 20) begin
            @(negedge clk);
            k++;
         end
         check("reach_addr15", 32'(imem_addr), 32'(15));
      end
      imem[0] = ins(3'd7, 4'd0, 4'd0);
      wait_halt(50);

      // Fetch stall: five cycles without ack, IR keeps the previous HALT.
      clear_imem();
      imem[0] = ins(3'd4, 4'd0, 4'd7);
      imem[1] = ins(3'd7, 4'd0, 4'd0);
      exp_f(0); exp_f(1);
      exp_d(4, 0, 7); exp_d(7, 0, 0);
      q_run.push_back(2); q_run.push_back(1);
      exp_h(2, 1, 0);
      ack_en = 1'b0;
      do_start();
      for (int i = 1; i <= 5; i++) begin
         check("stall_hold", 32'({imem_req, imem_addr, opcode, mem_addr, imm_val, dec_en}),
               32'({1'b1, PCW'(0), 3'd7, 4'd0, 4'd0, 1'b0}));
         if (i < 5) @(negedge clk);
      end
      ack_en = 1'b1;
      @(negedge clk);
      check("ack_cycle_req", 32'({imem_req, dec_en}), 32'(2'b10));
      @(negedge clk);
      check("decode_after_ack", 32'({dec_en, imem_req, opcode}), 32'({1'b1, 1'b0, 3'd4}));
      wait_halt(50);

      repeat (2) @(negedge clk);
      check("fetch_queue_empty", 32'(q_fetch.size()), 32'(0));
      check("decode_queue_empty", 32'(q_dec.size()), 32'(0));
      check("run_queue_empty", 32'(q_run.size()), 32'(0));
      check("halt_queue_empty", 32'(q_halt.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
